led_flow_monitor: RTL and testbench
===================================

Name: led_flow_monitor

Overview:
- Receive-side companion to the LED flow driver. Watches an 8-bit rotating one-hot LED bus and decodes the current position, the rotation direction and the step period in clock cycles.
- Flags malformed patterns (not one-hot), skipped positions and stalls.
- Sits on the board next to the LED output for self-check and display feedback. Same clock domain as the driver.

Parameters:
PERIOD_W, 32, width of the step-period counter and of the period output
STALL_MAX, 100000000, cycles without an LED change before stalled asserts (must be less than 2^PERIOD_W-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
led_in  input  8  observed LED bus; bit i lit = position i
clr  input  1  synchronous clear of step_count and error counters
pos  output  3  index of the lit LED; valid when pos_valid=1
pos_valid  output  1  level: a legal one-hot is being tracked
dir  output  1  1 = rotating toward MSB (bit i to i+1, 7 to 0); 0 = toward LSB
dir_valid  output  1  level: direction established
step_pulse  output  1  one-cycle pulse per legal adjacent step
dir_flip  output  1  one-cycle pulse when a step reverses dir
period  output  PERIOD_W  cycles between the last two steps; updates on period_valid
period_valid  output  1  one-cycle pulse when period is updated
err_onehot  output  1  one-cycle pulse: pattern not one-hot (zero or multiple bits)
err_jump  output  1  one-cycle pulse: new one-hot not adjacent to the previous one
stalled  output  1  level: no change for STALL_MAX cycles while tracking
step_count  output  16  legal steps since reset/clr, wraps 0xFFFF to 0
err_count  output  8  err_onehot plus err_jump events, saturates at 255

Behaviour:
- Input stage: led_in is registered into led_s every cycle. led_s is compared with led_last, the last accepted pattern.
  - Change = led_s != led_last.
  - All outputs are registered, so the response appears 2 clk edges after led_in changes.
- Reset (rst_n=0, async):
  - State goes to IDLE; led_s and led_last go to 0; the counter goes to 0.
  - Every output goes to 0.
- Adjacency, with modulo-8 arithmetic on pos:
  - "fwd" = new pos is (pos+1) mod 8.
  - "back" = new pos is (pos-1) mod 8.
  - Wrap between 7 and 0 is a legal step.
- FSM states: IDLE, ACQ, TRACK.
- IDLE:
  - Nothing tracked; pos_valid=0, dir_valid=0.
  - led_s one-hot → latch pos and led_last, pos_valid=1, counter=0, go to ACQ.
  - led_s non-zero and not one-hot → err_onehot pulse; stay in IDLE.
  - led_s=0 is silent in IDLE.
- ACQ, on a change:
  - fwd or back → dir=1 on fwd, 0 on back; dir_valid=1; step_pulse; counter=0; go to TRACK. No period is output, because the first interval is unknown.
  - Any other one-hot → err_jump; re-latch pos; counter=0; stay in ACQ.
  - Not one-hot → err_onehot; pos_valid=0; go to IDLE.
- TRACK, on a change:
  - Step in the current dir → step_pulse, period=counter+1, period_valid, counter=0.
  - Step opposite to dir → same as above, plus dir toggles and dir_flip pulses.
  - Non-adjacent one-hot → err_jump; dir_valid=0; re-latch pos; go to ACQ.
  - Not one-hot → err_onehot; pos_valid=0; dir_valid=0; go to IDLE.
- Counter:
  - Increments every cycle in ACQ and TRACK; saturates at all-ones.
  - stalled=1 when counter >= STALL_MAX-1 and no change this cycle.
  - stalled clears on the cycle any change is accepted, and on entry to IDLE.
- Counters:
  - step_count increments on every step_pulse.
  - err_count increments on each error pulse; err_onehot and err_jump are mutually exclusive.
- clr:
  - Zeroes step_count and err_count.
  - If an increment occurs in the same cycle, clr wins.
  - FSM, pos, dir and period are unaffected.
- Reset mid-operation: immediate return to reset values. After release, the first sample re-acquires from IDLE.

Optional Feature:
LED_MON_SYNC_EN:
- Defined: a 2-flop synchronizer (reset to 0) precedes led_s, so led_in may be asynchronous, e.g. from board pins. Latency becomes 4 edges.
- Undefined: single input register only; latency 2 edges.

Test Plan:
- Reset, then led_in=8'h01 held → 2 edges later pos=0, pos_valid=1, dir_valid=0; no error pulses.
- 01→02→04, each held 10 cycles → step_pulse twice; dir=1; the 04 step gives period=10; step_count=2.
- 80→01→02 → wrap 7→0 accepted as fwd, dir=1; then 02→01 → dir_flip, dir=0, period=10.
- While tracking 04, apply 8'h24 → err_onehot, pos_valid=0, state IDLE, err_count+1; then apply 8'h10 → ACQ, pos=4.
- In TRACK at pos 2, apply 8'h40 → err_jump, dir_valid=0, pos=6; then 8'h20 → dir=0, TRACK.
- STALL_MAX=50, hold 8'h08 in TRACK → stalled=1 after 50 cycles; next step → stalled=0, period saturates nowhere (=step gap); clr pulse → step_count=0, err_count=0.

Source files
------------

// File: rtl/led_flow_monitor.sv
// -----------------------------------------------------------------------------
// led_flow_monitor
//   Receive-side checker for a rotating one-hot LED bus. It decodes the lit
//   position, the rotation direction and the step period in clock cycles. It
//   also flags malformed patterns, non-adjacent jumps and stalls.
//
//   Compile-time option:
//     LED_MON_SYNC_EN  defined: led_in passes through a 2-flop synchronizer
//                      before led_s (response 4 edges after a change).
//                      undefined: single input register (response 2 edges).
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     led_in[7:0]  observed LED bus, bit i lit = position i
//     clr          synchronous clear of step_count and err_count
//     pos[2:0]     index of the lit LED (meaningful while pos_valid)
//     pos_valid    level: a legal one-hot is being tracked
//     dir          1 = rotating toward MSB (7 wraps to 0), 0 = toward LSB
//     dir_valid    level: direction established
//     step_pulse   one-cycle pulse per legal adjacent step
//     dir_flip     one-cycle pulse when a step reverses the direction
//     period       cycles between the last two steps
//     period_valid one-cycle pulse when period is updated
//     err_onehot   one-cycle pulse: pattern is zero or has several bits lit
//     err_jump     one-cycle pulse: new one-hot is not adjacent to the old one
//     stalled      level: no change for STALL_MAX cycles while tracking
//     step_count   legal steps since reset/clr, wraps
//     err_count    error pulses since reset/clr, saturates at 255
// -----------------------------------------------------------------------------
module led_flow_monitor #(
    parameter int PERIOD_W  = 32,
    parameter int STALL_MAX = 100000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          led_in,
    input  logic                clr,
    output logic [2:0]          pos,
    output logic                pos_valid,
    output logic                dir,
    output logic                dir_valid,
    output logic                step_pulse,
    output logic                dir_flip,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                err_onehot,
    output logic                err_jump,
    output logic                stalled,
    output logic [15:0]         step_count,
    output logic [7:0]          err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] STALL_TH = PERIOD_W'(STALL_MAX - 1);

    state_t              state, state_n;
    logic [7:0]          led_s, led_last, last_n;
    logic [PERIOD_W-1:0] cnt, cnt_n, cnt_inc, period_n;
    logic [2:0]          pos_n, new_pos;
    logic                pv_n, dir_n, dv_n, step_n, flip_n, perv_n;
    logic                eoh_n, ej_n, stalled_n;
    logic [15:0]         step_count_n;
    logic [7:0]          err_count_n;
    logic                change, is_onehot, fwd, back;

    // ---------------- input stage ----------------
`ifdef LED_MON_SYNC_EN
    logic [7:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
            led_s <= 8'h00;
        end else begin
            sync1 <= led_in;
            sync2 <= sync1;
            led_s <= sync2;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_s <= 8'h00;
        else        led_s <= led_in;
    end
`endif

    // Index of the highest lit bit; only used when led_s is one-hot.
    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign change    = (led_s != led_last);
    assign is_onehot = $onehot(led_s);
    assign new_pos   = encode(led_s);
    // 3-bit arithmetic gives the 7<->0 wrap for free.
    assign fwd       = (new_pos == pos + 3'd1);
    assign back      = (new_pos == pos - 3'd1);
    assign cnt_inc   = (&cnt) ? cnt : cnt + PERIOD_W'(1);

    // ---------------- next-state / next-output logic ----------------
    always_comb begin
        state_n  = state;
        last_n   = led_last;
        pos_n    = pos;
        pv_n     = pos_valid;
        dir_n    = dir;
        dv_n     = dir_valid;
        step_n   = 1'b0;
        flip_n   = 1'b0;
        period_n = period;
        perv_n   = 1'b0;
        eoh_n    = 1'b0;
        ej_n     = 1'b0;
        cnt_n    = cnt_inc;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                dv_n  = 1'b0;
                if (change) last_n = led_s;
                if (is_onehot) begin
                    pos_n   = new_pos;
                    pv_n    = 1'b1;
                    state_n = ACQ;
                end else if (change && led_s != 8'h00) begin
                    // Gated by change so a held bad pattern reports once.
                    eoh_n = 1'b1;
                end
            end
            ACQ: begin
                if (change) begin
                    last_n = led_s;
                    if (is_onehot && (fwd || back)) begin
                        // First interval is unknown, so no period here.
                        pos_n   = new_pos;
                        dir_n   = fwd;
                        dv_n    = 1'b1;
                        step_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = TRACK;
                    end else if (is_onehot) begin
                        ej_n  = 1'b1;
                        pos_n = new_pos;
                        cnt_n = '0;
                    end else begin
                        eoh_n   = 1'b1;
                        pv_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            TRACK: begin
                if (change) begin
                    last_n = led_s;
                    if (is_onehot && (fwd || back)) begin
                        pos_n    = new_pos;
                        step_n   = 1'b1;
                        period_n = cnt_inc;
                        perv_n   = 1'b1;
                        cnt_n    = '0;
                        if (fwd != dir) begin
                            dir_n  = fwd;
                            flip_n = 1'b1;
                        end
                    end else if (is_onehot) begin
                        ej_n    = 1'b1;
                        dv_n    = 1'b0;
                        pos_n   = new_pos;
                        cnt_n   = '0;
                        state_n = ACQ;
                    end else begin
                        eoh_n   = 1'b1;
                        pv_n    = 1'b0;
                        dv_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                pv_n    = 1'b0;
                dv_n    = 1'b0;
                cnt_n   = '0;
            end
        endcase

        stalled_n = (state != IDLE) && !change && (cnt >= STALL_TH);

        // clr takes priority over a same-cycle increment.
        if (clr)         step_count_n = 16'd0;
        else if (step_n) step_count_n = step_count + 16'd1;
        else             step_count_n = step_count;

        if (clr)                                      err_count_n = 8'd0;
        else if ((eoh_n || ej_n) && err_count != 8'hFF) err_count_n = err_count + 8'd1;
        else                                          err_count_n = err_count;
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            led_last     <= 8'h00;
            cnt          <= '0;
            pos          <= 3'd0;
            pos_valid    <= 1'b0;
            dir          <= 1'b0;
            dir_valid    <= 1'b0;
            step_pulse   <= 1'b0;
            dir_flip     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            err_onehot   <= 1'b0;
            err_jump     <= 1'b0;
            stalled      <= 1'b0;
            step_count   <= 16'd0;
            err_count    <= 8'd0;
        end else begin
            state        <= state_n;
            led_last     <= last_n;
            cnt          <= cnt_n;
            pos          <= pos_n;
            pos_valid    <= pv_n;
            dir          <= dir_n;
            dir_valid    <= dv_n;
            step_pulse   <= step_n;
            dir_flip     <= flip_n;
            period       <= period_n;
            period_valid <= perv_n;
            err_onehot   <= eoh_n;
            err_jump     <= ej_n;
            stalled      <= stalled_n;
            step_count   <= step_count_n;
            err_count    <= err_count_n;
        end
    end

endmodule

// File: tb/tb_led_flow_monitor.sv
// -----------------------------------------------------------------------------
// tb_led_flow_monitor
//   Drives led_flow_monitor with directed scenarios and random LED traffic.
//   A timestamp-based reference model predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_led_flow_monitor;

    localparam int PERIOD_W  = 32;
    localparam int STALL_MAX = 50;
`ifdef LED_MON_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif
    localparam int VW = 36 + PERIOD_W;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic clr = 1'b0;

    logic [2:0]          pos;
    logic                pos_valid, dir, dir_valid, step_pulse, dir_flip;
    logic [PERIOD_W-1:0] period;
    logic                period_valid, err_onehot, err_jump, stalled;
    logic [15:0]         step_count;
    logic [7:0]          err_count;

    always #5 clk = ~clk;

    led_flow_monitor #(.PERIOD_W(PERIOD_W), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .led_in(led_in), .clr(clr),
        .pos(pos), .pos_valid(pos_valid), .dir(dir), .dir_valid(dir_valid),
        .step_pulse(step_pulse), .dir_flip(dir_flip), .period(period),
        .period_valid(period_valid), .err_onehot(err_onehot), .err_jump(err_jump),
        .stalled(stalled), .step_count(step_count), .err_count(err_count)
    );

    logic [VW-1:0] obs_vec;
    assign obs_vec = {pos, pos_valid, dir, dir_valid, step_pulse, dir_flip, period,
                      period_valid, err_onehot, err_jump, stalled, step_count, err_count};

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] obs_q[$];
    int            cyc_q[$];
    logic [7:0]    dly_q[$];
    int checks = 0;
    int errors = 0;
    int cyc;

    // ---------------- reference model ----------------
    // m_mode: 0 = nothing known, 1 = position known, 2 = position and direction
    int         m_mode, m_pos, m_zero, m_last_step, m_steps, m_errs;
    bit         m_dir, m_step, m_flip, m_perv, m_eoh, m_ej, m_stalled;
    logic [7:0] m_last;
    longint     m_period;
    int         drv;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_dir = 0; m_last = 8'h00;
        m_zero = 0; m_last_step = 0; m_period = 0;
        m_step = 0; m_flip = 0; m_perv = 0; m_eoh = 0; m_ej = 0; m_stalled = 0;
        m_steps = 0; m_errs = 0; cyc = 0;
        dly_q.delete();
        for (int i = 0; i < D; i++) dly_q.push_back(8'h00);
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {3'(m_pos), (m_mode != 0), m_dir, (m_mode == 2), m_step, m_flip,
                PERIOD_W'(m_period), m_perv, m_eoh, m_ej, m_stalled,
                16'(m_steps), 8'(m_errs)};
    endfunction

    // One clock edge of the model; v is the pattern the monitor sees this edge.
    task automatic model_edge(input logic [7:0] v, input bit c);
        bit oh, chg, fw, bk;
        int np;
        np = 0;
        for (int i = 0; i < 8; i++) if (v[i]) np = i;
        oh  = ($countones(v) == 1);
        chg = (v != m_last);
        fw  = (np == (m_pos + 1) % 8);
        bk  = (np == (m_pos + 7) % 8);
        m_step = 0; m_flip = 0; m_perv = 0; m_eoh = 0; m_ej = 0;
        m_stalled = (m_mode != 0) && !chg && (cyc - m_zero >= STALL_MAX);
        if (chg) m_last = v;
        if (m_mode == 0) begin
            if (oh) begin
                m_pos = np; m_mode = 1; m_zero = cyc;
            end else if (chg && v != 8'h00) begin
                m_eoh = 1;
            end
        end else if (chg) begin
            if (oh && (fw || bk)) begin
                if (m_mode == 2) begin
                    m_period = cyc - m_last_step;
                    m_perv   = 1;
                    m_flip   = (fw != m_dir);
                end
                m_dir = fw; m_mode = 2; m_step = 1; m_pos = np;
                m_zero = cyc; m_last_step = cyc;
            end else if (oh) begin
                m_ej = 1; m_mode = 1; m_pos = np; m_zero = cyc;
            end else begin
                m_eoh = 1; m_mode = 0;
            end
        end
        if (c) begin
            m_steps = 0; m_errs = 0;
        end else begin
            if (m_step) m_steps = (m_steps + 1) % 65536;
            if ((m_eoh || m_ej) && m_errs < 255) m_errs++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; inputs change away from the active edge.
    task automatic tick(input logic [7:0] v, input logic c);
        logic [7:0] vs;
        led_in = v;
        clr    = c;
        dly_q.push_back(v);
        vs = dly_q.pop_front();
        @(posedge clk);
        cyc++;
        model_edge(vs, c);
        #1;
        obs_q.push_back(obs_vec);
        exp_q.push_back(exp_vec());
        cyc_q.push_back(cyc);
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        repeat (n) tick(v, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [VW-1:0] o, e;
        int n;
        rst_n = 1'b0; led_in = 8'hFF; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_vec !== '0) begin
            errors++; $display("FAIL reset_outputs got %h expected 0", obs_vec);
        end
        led_in = 8'h00;
        rst_n  = 1'b1;
        model_reset();
        hold(8'h01, D);
        checks++;
        if (pos_valid !== 1'b0) begin
            errors++; $display("FAIL acq_latency_early pos_valid got %b expected 0", pos_valid);
        end
        hold(8'h01, 1);
        checks++;
        if (pos_valid !== 1'b1 || pos !== 3'd0) begin
            errors++; $display("FAIL acq_pos got pos=%0d valid=%b expected pos=0 valid=1", pos, pos_valid);
        end
        checks++;
        if (dir_valid !== 1'b0 || err_count !== 8'd0) begin
            errors++; $display("FAIL acq_flags got dir_valid=%b err_count=%0d expected 0 0", dir_valid, err_count);
        end
        hold(8'h01, 3);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_reset cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_forward();
        logic [VW-1:0] o, e;
        int n;
        hold(8'h02, 10);
        hold(8'h04, 10);
        checks++;
        if (dir !== 1'b1 || dir_valid !== 1'b1) begin
            errors++; $display("FAIL fwd_dir got dir=%b valid=%b expected 1 1", dir, dir_valid);
        end
        checks++;
        if (period !== PERIOD_W'(10)) begin
            errors++; $display("FAIL fwd_period got %0d expected 10", period);
        end
        checks++;
        if (step_count !== 16'd2) begin
            errors++; $display("FAIL fwd_step_count got %0d expected 2", step_count);
        end
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_forward cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [VW-1:0] o, e;
        int n;
        hold(8'h80, 10);
        hold(8'h01, 10);
        checks++;
        if (dir !== 1'b1 || dir_valid !== 1'b1 || pos !== 3'd0) begin
            errors++; $display("FAIL wrap_fwd got dir=%b valid=%b pos=%0d expected 1 1 0", dir, dir_valid, pos);
        end
        hold(8'h02, 10);
        hold(8'h01, 10);
        checks++;
        if (dir !== 1'b0 || period !== PERIOD_W'(10)) begin
            errors++; $display("FAIL wrap_flip got dir=%b period=%0d expected 0 10", dir, period);
        end
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_wrap cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_onehot_err();
        logic [VW-1:0] o, e;
        logic [7:0] e0;
        int n;
        hold(8'h02, 10);
        hold(8'h04, 10);
        e0 = 8'(m_errs);
        hold(8'h24, 10);
        checks++;
        if (pos_valid !== 1'b0 || dir_valid !== 1'b0) begin
            errors++; $display("FAIL onehot_drop got pos_valid=%b dir_valid=%b expected 0 0", pos_valid, dir_valid);
        end
        checks++;
        if (err_count !== e0 + 8'd1) begin
            errors++; $display("FAIL onehot_count got %0d expected %0d", err_count, e0 + 8'd1);
        end
        hold(8'h10, 10);
        checks++;
        if (pos !== 3'd4 || pos_valid !== 1'b1 || dir_valid !== 1'b0) begin
            errors++; $display("FAIL onehot_reacq got pos=%0d pv=%b dv=%b expected 4 1 0", pos, pos_valid, dir_valid);
        end
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_onehot cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_jump();
        logic [VW-1:0] o, e;
        int n;
        hold(8'h08, 10);
        hold(8'h04, 10);
        hold(8'h02, 10);
        hold(8'h40, 10);
        checks++;
        if (pos !== 3'd6 || dir_valid !== 1'b0 || pos_valid !== 1'b1) begin
            errors++; $display("FAIL jump_relatch got pos=%0d dv=%b pv=%b expected 6 0 1", pos, dir_valid, pos_valid);
        end
        hold(8'h20, 10);
        checks++;
        if (dir !== 1'b0 || dir_valid !== 1'b1) begin
            errors++; $display("FAIL jump_retrack got dir=%b dv=%b expected 0 1", dir, dir_valid);
        end
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_jump cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_stall_clr();
        logic [VW-1:0] o, e;
        int n;
        hold(8'h10, 10);
        hold(8'h08, D + STALL_MAX);
        checks++;
        if (stalled !== 1'b0) begin
            errors++; $display("FAIL stall_early got %b expected 0", stalled);
        end
        hold(8'h08, 1);
        checks++;
        if (stalled !== 1'b1) begin
            errors++; $display("FAIL stall_set got %b expected 1", stalled);
        end
        hold(8'h08, 9);
        hold(8'h04, 10);
        checks++;
        if (stalled !== 1'b0 || period !== PERIOD_W'(D + STALL_MAX + 10)) begin
            errors++; $display("FAIL stall_release got stalled=%b period=%0d expected 0 %0d",
                               stalled, period, D + STALL_MAX + 10);
        end
        tick(8'h04, 1'b1);
        checks++;
        if (step_count !== 16'd0 || err_count !== 8'd0) begin
            errors++; $display("FAIL clr got steps=%0d errs=%0d expected 0 0", step_count, err_count);
        end
        hold(8'h04, 2);
        drv = 2;
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_stall cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] o, e;
        logic [7:0] bad_tab[7] = '{8'h00, 8'h03, 8'h24, 8'h81, 8'hFF, 8'h5A, 8'hC0};
        logic [7:0] v;
        int n, r, len;
        v = 8'h04;
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 65 && drv >= 0) begin
                drv = (drv + (($urandom_range(0, 1) == 1) ? 1 : 7)) % 8;
                v = 8'h01 << drv;
            end else if (r < 80) begin
                drv = $urandom_range(0, 7);
                v = 8'h01 << drv;
            end else if (r < 92) begin
                v = bad_tab[$urandom_range(0, 6)];
                drv = -1;
            end
            len = ($urandom_range(0, 19) == 0) ? 55 : $urandom_range(1, 8);
            repeat (len) tick(v, ($urandom_range(0, 40) == 0));
        end
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_random cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_saturate();
        logic [VW-1:0] o, e;
        int n;
        for (int k = 0; k < 150; k++) begin
            tick(8'h03, 1'b0);
            tick(8'h05, 1'b0);
        end
        checks++;
        if (err_count !== 8'hFF) begin
            errors++; $display("FAIL err_saturate got %0d expected 255", err_count);
        end
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_saturate cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] o, e;
        int n;
        hold(8'h01, 6);
        hold(8'h02, 6);
        hold(8'h04, 6);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_pre_reset cycle %0d got %h expected %h", n, o, e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got %h expected 0", obs_vec);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        hold(8'h04, D + 2);
        checks++;
        if (pos !== 3'd2 || pos_valid !== 1'b1 || dir_valid !== 1'b0 || step_count !== 16'd0) begin
            errors++; $display("FAIL mid_reset_reacq got pos=%0d pv=%b dv=%b steps=%0d expected 2 1 0 0",
                               pos, pos_valid, dir_valid, step_count);
        end
        hold(8'h08, 5);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n = cyc_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL trace_mid_reset cycle %0d got %h expected %h", n, o, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drv = -1;
        model_reset();
        test_reset();
        test_forward();
        test_wrap();
        test_onehot_err();
        test_jump();
        test_stall_clr();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
